// File: rtl/maxpool_stream_if.sv
// Valid/ready bundle for maxpool_stream: sample beat in, pooled result beat out, window status.
// slave is the pooling stage's view; master is the neighbour driving samples and taking results.
interface maxpool_stream_if #(
  parameter int DATA_W = 8,
  parameter int POOL_K = 2
);
  localparam int CNT_W = $clog2(POOL_K + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [CNT_W-1:0]  win_cnt;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, win_cnt
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, win_cnt
  );
endinterface

// File: rtl/maxpool_stream.sv
// Streaming 1-D max-pool over POOL_K samples (last flushes early); result registered 1 cycle after the closing beat.
// in_ready = ~out_valid | out_ready, so a held result stalls input. MAXPOOL_RELU_FUSE_EN clamps negative results to 0.
module maxpool_stream #(
  parameter int DATA_W     = 8,
  parameter int POOL_K     = 2,
  parameter int SIGNED_CMP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  maxpool_stream_if.slave   bus
);
  localparam int               CNT_W    = $clog2(POOL_K + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(POOL_K - 1);

  logic [DATA_W-1:0] run_max;
  logic [DATA_W-1:0] win_max;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] out_data_q;
  logic [CNT_W-1:0]  win_cnt_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              in_gt;
  logic              accept;
  logic              close;
  logic              drain;

  generate
    if (SIGNED_CMP != 0) begin : g_signed_cmp
      assign in_gt = $signed(bus.in_data) > $signed(run_max);
    end else begin : g_unsigned_cmp
      assign in_gt = bus.in_data > run_max;
    end
  endgenerate

  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign drain        = out_valid_q & bus.out_ready;
  assign close        = accept & ((win_cnt_q == LAST_IDX) | bus.in_last);

  // First sample of a window ignores the stale running max.
  assign win_max = ((win_cnt_q == '0) || in_gt) ? bus.in_data : run_max;

`ifdef MAXPOOL_RELU_FUSE_EN
  assign result = ((SIGNED_CMP != 0) && win_max[DATA_W-1]) ? '0 : win_max;
`else
  assign result = win_max;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_max     <= '0;
      win_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (drain) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        run_max <= win_max;
        // A closing beat overrides the drain clear so back-to-back results keep flowing.
        if (close) begin
          out_valid_q <= 1'b1;
          out_data_q  <= result;
          out_last_q  <= bus.in_last;
          win_cnt_q   <= '0;
        end else begin
          win_cnt_q <= win_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.win_cnt   = win_cnt_q;
endmodule

// File: tb/tb_maxpool_stream.sv
// Scoreboard bench for maxpool_stream: three instances (K2 signed, K2 unsigned, K3 signed) share one stimulus bus.
// Expected results are queued at the closing beat and popped by an independent output monitor.
module tb_maxpool_stream;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  int         sel = 0;
  logic       ordy = 1'b1;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  typedef struct {
    int         k;
    logic [7:0] d;
    logic       l;
    int         acc;
    logic       lat;
  } exp_t;
  exp_t exp_q[$];

  maxpool_stream_if #(.DATA_W(8), .POOL_K(2)) mp0 ();
  maxpool_stream_if #(.DATA_W(8), .POOL_K(2)) mp1 ();
  maxpool_stream_if #(.DATA_W(8), .POOL_K(3)) mp2 ();

  maxpool_stream #(.DATA_W(8), .POOL_K(2), .SIGNED_CMP(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(mp0));
  maxpool_stream #(.DATA_W(8), .POOL_K(2), .SIGNED_CMP(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(mp1));
  maxpool_stream #(.DATA_W(8), .POOL_K(3), .SIGNED_CMP(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(mp2));

  assign mp0.in_valid = s_valid && (sel == 0);
  assign mp1.in_valid = s_valid && (sel == 1);
  assign mp2.in_valid = s_valid && (sel == 2);
  assign mp0.in_data = s_data;
  assign mp1.in_data = s_data;
  assign mp2.in_data = s_data;
  assign mp0.in_last = s_last;
  assign mp1.in_last = s_last;
  assign mp2.in_last = s_last;
  assign mp0.out_ready = ordy;
  assign mp1.out_ready = ordy;
  assign mp2.out_ready = ordy;

  logic       rdy_sel;
  logic [2:0] ov;
  logic [7:0] od [3];
  logic [2:0] ol;
  assign rdy_sel = (sel == 0) ? mp0.in_ready : (sel == 1) ? mp1.in_ready : mp2.in_ready;
  assign ov = {mp2.out_valid, mp1.out_valid, mp0.out_valid};
  assign ol = {mp2.out_last, mp1.out_last, mp0.out_last};
  assign od[0] = mp0.out_data;
  assign od[1] = mp1.out_data;
  assign od[2] = mp2.out_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  // Inputs change at negedge+2; outputs are sampled at negedge+3, after every stimulus update.
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic send(input int k, input logic [7:0] d, input logic l,
                      input logic ex, input logic [7:0] ed, input logic el);
    int   n = 0;
    int   acc;
    logic lat;
    sel = k; s_data = d; s_last = l; s_valid = 1'b1;
    #1;
    while (!rdy_sel && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (!rdy_sel) begin
      chk("send_ready_timeout", {31'd0, rdy_sel}, 32'd1);
      step();
      s_valid = 1'b0;
    end else begin
      acc = cyc;
      lat = ordy;
      @(posedge clk);
      if (ex) exp_q.push_back('{k: k, d: ed, l: el, acc: acc, lat: lat});
      step();
      s_valid = 1'b0;
    end
  endtask

  task automatic drain_wait();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: every out_valid & out_ready transfer must match the head of the scoreboard.
  always begin
    exp_t e;
    @(negedge clk);
    #3;
    for (int k = 0; k < 3; k++) begin
      if (rst_n && ov[k] && ordy) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: dut%0d data 0x%0h, required no output", k, od[k]);
        end else begin
          e = exp_q.pop_front();
          chk("result_dut", k, e.k);
          chk("result_data", {24'd0, od[k]}, {24'd0, e.d});
          chk("result_last", {31'd0, ol[k]}, {31'd0, e.l});
          if (e.lat) chk("result_latency", cyc, e.acc + 1);
        end
      end
    end
  end

  logic [7:0] relu_exp;

  initial begin
`ifdef MAXPOOL_RELU_FUSE_EN
    relu_exp = 8'h00;
`else
    relu_exp = 8'hF0;
`endif
    repeat (2) @(negedge clk);
    #3;
    chk("rst_out_valid", {31'd0, mp0.out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, mp0.out_data}, 32'd0);
    chk("rst_out_last", {31'd0, mp0.out_last}, 32'd0);
    chk("rst_win_cnt", {30'd0, mp0.win_cnt}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, mp0.in_ready}, 32'd1);
    step();

    // Full-rate stream, two windows.
    send(0, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0);
    send(0, 8'h7F, 1'b0, 1'b1, 8'h7F, 1'b0);
    send(0, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0);
    send(0, 8'h03, 1'b0, 1'b1, 8'h10, 1'b0);
    // Signed vs unsigned ordering, and a tie.
    send(0, 8'h80, 1'b0, 1'b0, 8'h00, 1'b0);
    send(0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0);
    send(1, 8'h80, 1'b0, 1'b0, 8'h00, 1'b0);
    send(1, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0);
    send(1, 8'h42, 1'b0, 1'b0, 8'h00, 1'b0);
    send(1, 8'h42, 1'b0, 1'b1, 8'h42, 1'b0);
    // POOL_K=3: short frame flushed by last, then a full window.
    send(2, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
    #1 chk("k3_win_cnt_1", {30'd0, mp2.win_cnt}, 32'd1);
    send(2, 8'h09, 1'b1, 1'b1, 8'h09, 1'b1);
    #1 chk("k3_win_cnt_flush", {30'd0, mp2.win_cnt}, 32'd0);
    send(2, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0);
    send(2, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0);
    #1 chk("k3_win_cnt_2", {30'd0, mp2.win_cnt}, 32'd2);
    send(2, 8'h04, 1'b0, 1'b1, 8'h04, 1'b0);
    // Window of one via last on the first sample.
    send(0, 8'h7A, 1'b1, 1'b1, 8'h7A, 1'b1);
    // Negative maxima (clamped when ReLU fusion is built in).
    send(0, 8'hF0, 1'b0, 1'b0, 8'h00, 1'b0);
    send(0, 8'h85, 1'b0, 1'b1, relu_exp, 1'b0);
    send(0, 8'hF0, 1'b0, 1'b0, 8'h00, 1'b0);
    send(0, 8'h05, 1'b0, 1'b1, 8'h05, 1'b0);
    drain_wait();

    // Backpressure: first result drains, second is held, third waits for release.
    send(0, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0);
    send(0, 8'h22, 1'b0, 1'b1, 8'h22, 1'b0);
    step();
    ordy = 1'b0;
    send(0, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0);
    send(0, 8'h44, 1'b0, 1'b1, 8'h44, 1'b0);
    fork
      send(0, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0);
      begin
        for (int i = 0; i < 3; i++) begin
          #1;
          chk("bp_out_valid", {31'd0, mp0.out_valid}, 32'd1);
          chk("bp_out_data", {24'd0, mp0.out_data}, 32'h44);
          chk("bp_in_ready", {31'd0, mp0.in_ready}, 32'd0);
          step();
        end
        ordy = 1'b1;
      end
    join
    send(0, 8'h66, 1'b0, 1'b1, 8'h66, 1'b0);
    drain_wait();

    // Reset with a half-filled window discards it.
    send(0, 8'h40, 1'b0, 1'b0, 8'h00, 1'b0);
    #1 chk("pre_rst_win_cnt", {30'd0, mp0.win_cnt}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, mp0.out_valid}, 32'd0);
    chk("mid_rst_out_data", {24'd0, mp0.out_data}, 32'd0);
    chk("mid_rst_win_cnt", {30'd0, mp0.win_cnt}, 32'd0);
    step();
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", {31'd0, mp0.in_ready}, 32'd1);
    step();
    send(0, 8'h20, 1'b0, 1'b0, 8'h00, 1'b0);
    send(0, 8'h30, 1'b0, 1'b1, 8'h30, 1'b0);
    drain_wait();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
